// File: rtl/vm2002_common_pkg.sv
// Shared types and constants for the vm2002 change path.
// Coin encodings, coin values and dispenser FSM states.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coins_t;

  localparam logic [7:0] NICKEL_VAL  = 8'd5;
  localparam logic [7:0] DIME_VAL    = 8'd10;
  localparam logic [7:0] QUARTER_VAL = 8'd25;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } chg_state_t;

  function automatic logic [7:0] coin_val(coins_t c);
    logic [7:0] v;
    v = 8'd0;
    unique case (c)
      NICKEL:  v = NICKEL_VAL;
      DIME:    v = DIME_VAL;
      QUARTER: v = QUARTER_VAL;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm2002_change_dispenser_if.sv
// Control, refill and coin-stream bundle of the change dispenser.
// master drives requests and refills; slave is the dispenser.
interface vm2002_change_dispenser_if #(
  parameter int INV_W = 6
);
  import vm2002_common_pkg::*;

  logic             start;
  logic [7:0]       balance;
  logic             hopper_rdy;
  logic             refill;
  coins_t           refill_coin;
  logic [INV_W-1:0] refill_count;
  coins_t           coin_out;
  logic             coin_valid;
  logic             busy;
  logic             done;
  logic [7:0]       shortfall;
  logic             exact_change;

  modport master (
    output start, balance, hopper_rdy,
    output refill, refill_coin, refill_count,
    input  coin_out, coin_valid, busy,
    input  done, shortfall, exact_change
  );

  modport slave (
    input  start, balance, hopper_rdy,
    input  refill, refill_coin, refill_count,
    output coin_out, coin_valid, busy,
    output done, shortfall, exact_change
  );

endinterface

// File: rtl/vm2002_coin_tube.sv
// One denomination tube: saturating inventory counter.
// Refill and take may land on the same edge.
module vm2002_coin_tube #(
  parameter int INV_W = 6,
  parameter int INIT  = 20
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             add,
  input  logic [INV_W-1:0] add_count,
  input  logic             take,
  output logic [INV_W-1:0] count,
  output logic             empty
);

  localparam logic [INV_W:0] MAX = {1'b0, {INV_W{1'b1}}};
  localparam logic [INV_W-1:0] RST = INIT[INV_W-1:0];

  logic [INV_W-1:0] r_cnt;
  logic [INV_W:0]   w_inc;
  logic [INV_W:0]   w_sum;

  // take is only raised on a non-empty tube, so no underflow
  always_comb begin
    w_inc = add ? {1'b0, add_count} : '0;
    w_sum = {1'b0, r_cnt} + w_inc - {{INV_W{1'b0}}, take};
  end

  // inventory register, clamped at full scale
  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      r_cnt <= RST;
    end else if (w_sum > MAX) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= w_sum[INV_W-1:0];
    end
  end

  assign count = r_cnt;
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Greedy change dispenser: quarter/dime/nickel, one coin per
// ready hopper cycle, limited by the three tube inventories.
module vm2002_change_dispenser
  import vm2002_common_pkg::*;
#(
  parameter int INV_W  = 6,
  parameter int INIT_Q = 20,
  parameter int INIT_D = 20,
  parameter int INIT_N = 20
) (
  input logic clk,
  input logic hrst_n,
  input logic srst,
  vm2002_change_dispenser_if.slave bus
);

  chg_state_t       r_state, w_state;
  logic [7:0]       r_rem, w_rem;
  coins_t           r_coin, w_coin, w_sel;
  logic             r_valid, w_valid;
  logic             r_done, w_done;
  logic [7:0]       r_short, w_short;
  logic             r_exact;
  logic             w_take;
  logic [INV_W-1:0] w_q_cnt, w_d_cnt, w_n_cnt;
  logic             w_q_empty, w_d_empty, w_n_empty;

  // greedy choice against what the tubes still hold
  always_comb begin
    w_sel = NONE;
    if (r_rem >= QUARTER_VAL && !w_q_empty) begin
      w_sel = QUARTER;
    end else if (r_rem >= DIME_VAL && !w_d_empty) begin
      w_sel = DIME;
    end else if (r_rem >= NICKEL_VAL && !w_n_empty) begin
      w_sel = NICKEL;
    end
  end

  assign w_take = (r_state == DISPENSE) && (w_sel != NONE)
                && bus.hopper_rdy && !srst;

  // next state and registered outputs
  always_comb begin
    w_state = r_state;
    w_rem   = r_rem;
    w_coin  = NONE;
    w_valid = 1'b0;
    w_done  = 1'b0;
    w_short = 8'd0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_rem   = bus.balance;
          w_state = DISPENSE;
        end
      end
      DISPENSE: begin
        if (w_sel == NONE) begin
          w_state = DONE;
          w_done  = 1'b1;
          w_short = r_rem;
        end else if (bus.hopper_rdy) begin
          w_coin  = w_sel;
          w_valid = 1'b1;
          w_rem   = r_rem - coin_val(w_sel);
        end
      end
      DONE: begin
        w_state = IDLE;
        w_rem   = 8'd0;
      end
      default: w_state = IDLE;
    endcase
  end

  // state register; soft reset aborts but keeps inventory
  always_ff @(posedge clk) begin
    if (!hrst_n) begin
      r_state <= IDLE;
      r_rem   <= 8'd0;
      r_coin  <= NONE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 8'd0;
      r_exact <= (INIT_N == 0);
    end else begin
      r_exact <= w_n_empty;
      if (srst) begin
        r_state <= IDLE;
        r_rem   <= 8'd0;
        r_coin  <= NONE;
        r_valid <= 1'b0;
        r_done  <= 1'b0;
        r_short <= 8'd0;
      end else begin
        r_state <= w_state;
        r_rem   <= w_rem;
        r_coin  <= w_coin;
        r_valid <= w_valid;
        r_done  <= w_done;
        r_short <= w_short;
      end
    end
  end

  vm2002_coin_tube #(.INV_W(INV_W), .INIT(INIT_Q)) u_q (
    .clk       (clk),
    .hrst_n    (hrst_n),
    .add       (bus.refill && bus.refill_coin == QUARTER),
    .add_count (bus.refill_count),
    .take      (w_take && w_sel == QUARTER),
    .count     (w_q_cnt),
    .empty     (w_q_empty)
  );

  vm2002_coin_tube #(.INV_W(INV_W), .INIT(INIT_D)) u_d (
    .clk       (clk),
    .hrst_n    (hrst_n),
    .add       (bus.refill && bus.refill_coin == DIME),
    .add_count (bus.refill_count),
    .take      (w_take && w_sel == DIME),
    .count     (w_d_cnt),
    .empty     (w_d_empty)
  );

  vm2002_coin_tube #(.INV_W(INV_W), .INIT(INIT_N)) u_n (
    .clk       (clk),
    .hrst_n    (hrst_n),
    .add       (bus.refill && bus.refill_coin == NICKEL),
    .add_count (bus.refill_count),
    .take      (w_take && w_sel == NICKEL),
    .count     (w_n_cnt),
    .empty     (w_n_empty)
  );

  assign bus.coin_out     = r_coin;
  assign bus.coin_valid   = r_valid;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;
  assign bus.shortfall    = r_short;
  assign bus.exact_change = r_exact;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: two instances, one fully
// stocked and one with empty quarter/nickel tubes.
module tb_vm2002_change_dispenser;
  import vm2002_common_pkg::*;

  logic clk    = 1'b0;
  logic hrst_n = 1'b0;
  logic srst   = 1'b0;

  always #5 clk = ~clk;

  vm2002_change_dispenser_if #(.INV_W(6)) ifa ();
  vm2002_change_dispenser_if #(.INV_W(6)) ifb ();

  vm2002_change_dispenser #(
    .INV_W(6), .INIT_Q(20), .INIT_D(20), .INIT_N(20)
  ) dut_a (
    .clk(clk), .hrst_n(hrst_n), .srst(srst), .bus(ifa.slave)
  );

  vm2002_change_dispenser #(
    .INV_W(6), .INIT_Q(0), .INIT_D(20), .INIT_N(0)
  ) dut_b (
    .clk(clk), .hrst_n(hrst_n), .srst(srst), .bus(ifb.slave)
  );

  typedef struct {
    bit          s;
    logic [7:0]  bal;
    bit          tog;
    int          n;
    logic [31:0] coins;
    logic [7:0]  sf;
    int          dcyc;
  } vec_t;

  int errs   = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] g_coin(bit s);
    return s ? ifb.coin_out : ifa.coin_out;
  endfunction
  function automatic logic g_valid(bit s);
    return s ? ifb.coin_valid : ifa.coin_valid;
  endfunction
  function automatic logic g_busy(bit s);
    return s ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic g_done(bit s);
    return s ? ifb.done : ifa.done;
  endfunction
  function automatic logic [7:0] g_short(bit s);
    return s ? ifb.shortfall : ifa.shortfall;
  endfunction
  function automatic logic g_exact(bit s);
    return s ? ifb.exact_change : ifa.exact_change;
  endfunction
  function automatic logic [5:0] g_cnt(bit s, int c);
    logic [5:0] v;
    v = '0;
    case (c)
      3: v = s ? dut_b.w_q_cnt : dut_a.w_q_cnt;
      2: v = s ? dut_b.w_d_cnt : dut_a.w_d_cnt;
      default: v = s ? dut_b.w_n_cnt : dut_a.w_n_cnt;
    endcase
    return v;
  endfunction

  task automatic drv(bit s, logic st, logic [7:0] bal, logic rdy);
    if (s) begin
      ifb.start = st; ifb.balance = bal; ifb.hopper_rdy = rdy;
    end else begin
      ifa.start = st; ifa.balance = bal; ifa.hopper_rdy = rdy;
    end
  endtask

  task automatic run(vec_t v);
    int  i;
    bit  fin;
    i   = 0;
    fin = 0;
    @(negedge clk); drv(v.s, 1'b1, v.bal, 1'b1);
    @(posedge clk);
    @(negedge clk); drv(v.s, 1'b0, 8'd0, 1'b1);
    chk("busy_after_start", g_busy(v.s), 1);
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (g_valid(v.s)) begin
        chk("coin_cycle", cyc, v.tog ? 2 * i + 1 : i + 1);
        chk("coin", g_coin(v.s),
            i < v.n ? v.coins[2 * i +: 2] : 2'd0);
        i++;
      end else begin
        chk("coin_idle_none", g_coin(v.s), NONE);
      end
      if (g_done(v.s)) begin
        chk("shortfall", g_short(v.s), v.sf);
        chk("coin_total", i, v.n);
        chk("done_cycle", cyc, v.dcyc);
        fin = 1;
      end
      drv(v.s, 1'b0, 8'd0, v.tog ? (cyc % 2 == 0) : 1'b1);
    end
    chk("done_seen", fin, 1);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", g_done(v.s), 0);
    chk("busy_end", g_busy(v.s), 0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t one;
    vecs[0] = '{0, 8'd40,  0, 3,  32'h0000001B, 8'd0, 4};
    vecs[1] = '{1, 8'd50,  0, 5,  32'h000002AA, 8'd0, 6};
    vecs[2] = '{1, 8'd15,  0, 1,  32'h00000002, 8'd5, 2};
    vecs[3] = '{0, 8'd100, 1, 4,  32'h000000FF, 8'd0, 8};
    vecs[4] = '{0, 8'd0,   0, 0,  32'h00000000, 8'd0, 1};
    vecs[5] = '{0, 8'd7,   0, 1,  32'h00000001, 8'd2, 2};
    vecs[6] = '{0, 8'd255, 0, 11, 32'h001FFFFF, 8'd0, 12};
    vecs[7] = '{1, 8'd3,   0, 0,  32'h00000000, 8'd3, 1};
    vecs[8] = '{1, 8'd130, 0, 13, 32'h02AAAAAA, 8'd0, 14};

    drv(0, 1'b0, 8'd0, 1'b0);
    drv(1, 1'b0, 8'd0, 1'b0);
    ifa.refill = 1'b0; ifa.refill_coin = NONE; ifa.refill_count = '0;
    ifb.refill = 1'b0; ifb.refill_coin = NONE; ifb.refill_count = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", g_busy(0), 0);
    chk("rst_valid", g_valid(0), 0);
    chk("rst_coin", g_coin(0), NONE);
    chk("rst_done", g_done(0), 0);
    chk("rst_short", g_short(0), 0);
    chk("rst_exact_a", g_exact(0), 0);
    chk("rst_exact_b", g_exact(1), 1);
    chk("rst_q_a", g_cnt(0, 3), 20);
    chk("rst_q_b", g_cnt(1, 3), 0);
    hrst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run(vecs[k]);
      if (k == 0) begin
        chk("v0_q", g_cnt(0, 3), 19);
        chk("v0_d", g_cnt(0, 2), 19);
        chk("v0_n", g_cnt(0, 1), 19);
      end
    end
    chk("tbl_a_q", g_cnt(0, 3), 5);
    chk("tbl_a_d", g_cnt(0, 2), 19);
    chk("tbl_a_n", g_cnt(0, 1), 17);
    chk("tbl_b_d", g_cnt(1, 2), 1);

    // soft reset after the second coin of 100 cents
    @(negedge clk); drv(0, 1'b1, 8'd100, 1'b1);
    @(posedge clk);
    @(negedge clk); drv(0, 1'b0, 8'd0, 1'b1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("srst_pre_coin", g_valid(0), 1);
    end
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    chk("srst_valid", g_valid(0), 0);
    chk("srst_busy", g_busy(0), 0);
    chk("srst_done", g_done(0), 0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("srst_no_done", g_done(0), 0);
    end
    chk("srst_q_kept", g_cnt(0, 3), 3);
    one = '{0, 8'd25, 0, 1, 32'h00000003, 8'd0, 2};
    run(one);
    chk("after_srst_q", g_cnt(0, 3), 2);

    // start during done is ignored
    @(negedge clk); drv(0, 1'b1, 8'd0, 1'b1);
    @(posedge clk);
    @(negedge clk); drv(0, 1'b0, 8'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("zero_done", g_done(0), 1);
    drv(0, 1'b1, 8'd25, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b0, 8'd0, 1'b1);
    chk("start_in_done_busy", g_busy(0), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("start_in_done_idle", g_busy(0), 0);
    chk("start_in_done_q", g_cnt(0, 3), 2);

    // refill saturation and NONE refill
    ifa.refill = 1'b1; ifa.refill_coin = QUARTER; ifa.refill_count = 6'd63;
    @(posedge clk);
    @(negedge clk);
    ifa.refill = 1'b0;
    chk("sat_q", g_cnt(0, 3), 63);
    ifa.refill = 1'b1; ifa.refill_coin = NONE; ifa.refill_count = 6'd5;
    @(posedge clk);
    @(negedge clk);
    ifa.refill = 1'b0;
    chk("none_q", g_cnt(0, 3), 63);
    chk("none_d", g_cnt(0, 2), 19);
    chk("none_n", g_cnt(0, 1), 17);

    // refill dimes while dispensing from D=1
    @(negedge clk); drv(1, 1'b1, 8'd20, 1'b1);
    @(posedge clk);
    @(negedge clk); drv(1, 1'b0, 8'd0, 1'b1);
    ifb.refill = 1'b1; ifb.refill_coin = DIME; ifb.refill_count = 6'd5;
    @(posedge clk);
    @(negedge clk);
    ifb.refill = 1'b0;
    chk("rfd_valid1", g_valid(1), 1);
    chk("rfd_coin1", g_coin(1), DIME);
    chk("rfd_d1", g_cnt(1, 2), 5);
    @(posedge clk);
    @(negedge clk);
    chk("rfd_coin2", g_coin(1), DIME);
    chk("rfd_d2", g_cnt(1, 2), 4);
    @(posedge clk);
    @(negedge clk);
    chk("rfd_done", g_done(1), 1);
    chk("rfd_short", g_short(1), 0);

    // exact_change lags the nickel count by one cycle
    ifb.refill = 1'b1; ifb.refill_coin = NICKEL; ifb.refill_count = 6'd3;
    @(posedge clk);
    @(negedge clk);
    ifb.refill = 1'b0;
    chk("ex_n", g_cnt(1, 1), 3);
    chk("ex_lag", g_exact(1), 1);
    @(posedge clk);
    @(negedge clk);
    chk("ex_clear", g_exact(1), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
